uart_tx_scheduler: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_scheduler_rr_arbiter.sv | 36 +++
 rtl/uart_tx_scheduler.sv | 153 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the round-robin UART transmit scheduler.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, SYNC, START, DATA, STOP} uart_state_e;

    localparam int   DATA_W_DEFAULT = 8;
    localparam logic IDLE_LEVEL     = 1'b1;
    localparam int   STOP_BITS_MIN  = 1;
    localparam int   STOP_BITS_MAX  = 2;

    // Index width that stays at least one bit for single-entry cases.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, with wrap.
module rr_arbiter import uart_pkg::*; #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    logic [IDX_W:0] cand;
    logic           found;

    always_comb begin
        // NOTE: every output and temporary gets a default before the loop, so no path infers a latch.
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(NUM_REQ)) cand = cand - (IDX_W + 1)'(NUM_REQ);
            if (!found && req[cand[IDX_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
        if (en && found) grant[grant_idx] = 1'b1;
    end

    assign any = |req;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that frames bytes from NUM_REQ sources onto one UART tx line.
module uart_tx_scheduler import uart_pkg::*; #(
    parameter  int NUM_REQ   = 4,
    parameter  int DATA_W    = DATA_W_DEFAULT,
    parameter  int STOP_BITS = 1,
    localparam int IDX_W     = idx_width(NUM_REQ),
    localparam int BIT_W     = idx_width(DATA_W)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      baud_tick,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx,
    output logic                      busy,
    output logic [IDX_W-1:0]          active_id,
    output logic                      frame_done
);

    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
        $error("uart_tx_scheduler: STOP_BITS must be 1 or 2");
    end

    uart_state_e       state_q, state_d;
    logic              tx_q, tx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  active_id_q, active_id_d;
    logic              frame_done_q, frame_done_d;

    logic [DATA_W-1:0] req_bytes [NUM_REQ];
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               any_valid;
    logic               last_stop;
    logic               arb_en;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign req_bytes[g] = req_data[g*DATA_W +: DATA_W];
    end

    // Arbitrate in every IDLE cycle, and on the tick that closes the final stop bit.
    assign last_stop = (int'(stop_cnt_q) == STOP_BITS - 1);
    assign arb_en    = !reset && ((state_q == IDLE) ||
                                  (state_q == STOP && baud_tick && last_stop));

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any_valid)
    );

    always_comb begin
        state_d      = state_q;
        tx_d         = tx_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        stop_cnt_d   = stop_cnt_q;
        ptr_d        = ptr_q;
        active_id_d  = active_id_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d = IDLE_LEVEL;
                if (any_valid) state_d = SYNC;
            end
            SYNC: if (baud_tick) begin
                tx_d    = 1'b0;
                state_d = START;
            end
            START: if (baud_tick) begin
                tx_d      = shift_q[0];
                bit_idx_d = '0;
                state_d   = DATA;
            end
            DATA: if (baud_tick) begin
                if (bit_idx_q == BIT_W'(DATA_W - 1)) begin
                    tx_d       = IDLE_LEVEL;
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end else begin
                    bit_idx_d = bit_idx_q + 1'b1;
                    tx_d      = shift_q[bit_idx_q + 1'b1];
                end
            end
            STOP: if (baud_tick) begin
                if (!last_stop) begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end else begin
                    frame_done_d = 1'b1;
                    // Back-to-back: the closing tick of this frame opens the next start bit.
                    if (any_valid) begin
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = IDLE_LEVEL;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                tx_d    = IDLE_LEVEL;
                state_d = IDLE;
            end
        endcase

        if (arb_en && any_valid) begin
            shift_d     = req_bytes[grant_idx];
            active_id_d = grant_idx;
            ptr_d       = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            tx_q         <= IDLE_LEVEL;
            bit_idx_q    <= '0;
            stop_cnt_q   <= 1'b0;
            ptr_q        <= '0;
            active_id_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_q         <= tx_d;
            bit_idx_q    <= bit_idx_d;
            stop_cnt_q   <= stop_cnt_d;
            ptr_q        <= ptr_d;
            active_id_q  <= active_id_d;
            frame_done_q <= frame_done_d;
        end
    end

    // NOTE: the shift register has no reset; it is always loaded at acceptance before it is read.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign req_ready  = grant;
    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign active_id  = active_id_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: framing, round-robin order, back-to-back, stop bits, reset.
module tb_uart_tx_scheduler;
    timeunit 1ns;
    timeprecision 1ps;

    localparam int DIV = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        baud_tick = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        tx, busy, frame_done;
    logic [1:0]  active_id;

    logic [1:0]  req_valid2 = '0;
    logic [15:0] req_data2 = '0;
    logic [1:0]  req_ready2;
    logic        tx2, busy2, frame_done2;
    logic [0:0]  active_id2;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int phase = 0;
    int glitch_cnt = 0;
    int ready_err = 0;
    logic prev_tick = 1'b0;
    logic last_tx = 1'b1;

    logic bits_q[$];
    logic bits2_q[$];
    int   bits_cyc[$];
    int   grant_q[$];
    int   done_q[$];
    int   done2_q[$];

    always #5 clk = ~clk;

    uart_tx_scheduler #(.NUM_REQ(4), .DATA_W(8), .STOP_BITS(1)) dut (
        .clk(clk), .reset(reset), .baud_tick(baud_tick),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .tx(tx), .busy(busy), .active_id(active_id), .frame_done(frame_done)
    );

    uart_tx_scheduler #(.NUM_REQ(2), .DATA_W(8), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .baud_tick(baud_tick),
        .req_valid(req_valid2), .req_data(req_data2), .req_ready(req_ready2),
        .tx(tx2), .busy(busy2), .active_id(active_id2), .frame_done(frame_done2)
    );

    // Observe on the falling edge: tx level after each tick, grants, frame_done pulses.
    always @(negedge clk) begin
        cyc++;
        if (prev_tick) begin
            bits_q.push_back(tx);
            bits2_q.push_back(tx2);
            bits_cyc.push_back(cyc);
        end else if (tx !== last_tx) begin
            glitch_cnt++;
        end
        last_tx   = tx;
        prev_tick = baud_tick;
        if (req_ready != 4'b0000) begin
            if ($countones(req_ready) != 1) ready_err++;
            for (int i = 0; i < 4; i++) if (req_ready[i]) grant_q.push_back(i);
        end
        if (frame_done)  done_q.push_back(cyc);
        if (frame_done2) done2_q.push_back(cyc);
    end

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            phase     = (phase == DIV - 1) ? 0 : phase + 1;
            baud_tick = (phase == DIV - 1);
        end
    endtask

    task automatic run_until_tick();
        int g = 0;
        do begin
            run(1);
            g++;
        end while (baud_tick !== 1'b1 && g < 2 * DIV);
    endtask

    // Leaves the next clock edge free of baud_tick, with the last tick sample already taken.
    task automatic align_no_tick();
        run_until_tick();
        run(2);
    endtask

    task automatic clear_logs();
        bits_q.delete();
        bits2_q.delete();
        bits_cyc.delete();
        grant_q.delete();
        done_q.delete();
        done2_q.delete();
        glitch_cnt = 0;
        ready_err  = 0;
    endtask

    task automatic apply_reset();
        req_valid  = '0;
        req_valid2 = '0;
        reset      = 1'b1;
        run(2);
        reset      = 1'b0;
        run(2);
    endtask

    task automatic wait_bits(input int n, input string what);
        int budget = 4000;
        while (bits_q.size() < n && budget > 0) begin
            run(1);
            budget--;
        end
        n_cmp++;
        if (bits_q.size() < n) begin
            n_bad++;
            $display("FAIL %s: timeout, tick samples %0d, required %0d", what, bits_q.size(), n);
        end
    endtask

    task automatic wait_grants(input int n, input string what);
        int budget = 4000;
        while (grant_q.size() < n && budget > 0) begin
            run(1);
            budget--;
        end
        n_cmp++;
        if (grant_q.size() < n) begin
            n_bad++;
            $display("FAIL %s: timeout, grants %0d, required %0d", what, grant_q.size(), n);
        end
    endtask

    task automatic wait_done(input int n, input bit second, input string what);
        int budget = 4000;
        while ((second ? done2_q.size() : done_q.size()) < n && budget > 0) begin
            run(1);
            budget--;
        end
        n_cmp++;
        if ((second ? done2_q.size() : done_q.size()) < n) begin
            n_bad++;
            $display("FAIL %s: timeout, frame_done pulses %0d, required %0d", what,
                     second ? done2_q.size() : done_q.size(), n);
        end
    endtask

    function automatic logic [9:0] frame_bits(input int base);
        logic [9:0] v = 'x;
        for (int k = 0; k < 10; k++) if (base + k < bits_q.size()) v[k] = bits_q[base + k];
        return v;
    endfunction

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 4'b0001;
        run(2);
        n_cmp++; if (tx !== 1'b1)          begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_cmp++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (active_id !== 2'd0)   begin n_bad++; $display("FAIL reset_active_id: got %0d want 0", active_id); end
        n_cmp++; if (frame_done !== 1'b0)  begin n_bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        req_valid = '0;
        reset     = 1'b0;
        run(2);
    endtask

    task automatic test_single_frame();
        logic [9:0] exp_f;
        apply_reset();
        align_no_tick();
        req_data[7:0] = 8'hA5;
        req_valid     = 4'b0001;
        clear_logs();
        run(1);
        req_valid = '0;
        wait_bits(11, "single_bits");
        exp_f = {1'b1, 8'hA5, 1'b0};
        n_cmp++; if (frame_bits(0) !== exp_f) begin n_bad++; $display("FAIL single_frame: got %b want %b", frame_bits(0), exp_f); end
        n_cmp++; if (grant_q.size() != 1 || grant_q[0] != 0) begin n_bad++; $display("FAIL single_grant: count %0d, want one grant of req0", grant_q.size()); end
        n_cmp++; if (done_q.size() != 1 || done_q[0] != bits_cyc[10]) begin n_bad++; $display("FAIL single_done: count %0d, want 1 at end of stop bit", done_q.size()); end
        n_cmp++; if (bits_cyc[10] - bits_cyc[0] != 10 * DIV) begin n_bad++; $display("FAIL single_length: got %0d clks want %0d", bits_cyc[10] - bits_cyc[0], 10 * DIV); end
        n_cmp++; if (active_id !== 2'd0) begin n_bad++; $display("FAIL single_active_id: got %0d want 0", active_id); end
        n_cmp++; if (glitch_cnt != 0 || ready_err != 0) begin n_bad++; $display("FAIL single_clean: glitches %0d ready_errs %0d want 0", glitch_cnt, ready_err); end
    endtask

    task automatic test_round_robin();
        int         exp_order[5] = '{0, 1, 2, 3, 0};
        logic [7:0] b;
        logic [9:0] exp_f;
        apply_reset();
        align_no_tick();
        req_data  = 32'h1312_1110;
        req_valid = 4'hF;
        clear_logs();
        wait_grants(5, "rr_grants");
        req_valid = '0;
        wait_done(5, 1'b0, "rr_done");
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (k >= grant_q.size() || grant_q[k] != exp_order[k]) begin
                n_bad++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, (k < grant_q.size()) ? grant_q[k] : -1, exp_order[k]);
            end
        end
        for (int f = 0; f < 4; f++) begin
            b     = 8'h10 + 8'(f);
            exp_f = {1'b1, b, 1'b0};
            n_cmp++;
            if (frame_bits(10 * f) !== exp_f) begin n_bad++; $display("FAIL rr_frame[%0d]: got %b want %b", f, frame_bits(10 * f), exp_f); end
        end
        for (int f = 0; f < 3; f++) begin
            n_cmp++;
            if (done_q.size() < f + 2 || done_q[f + 1] - done_q[f] != 10 * DIV) begin
                n_bad++; $display("FAIL rr_done_gap[%0d]: got %0d want %0d", f, (done_q.size() >= f + 2) ? done_q[f + 1] - done_q[f] : -1, 10 * DIV);
            end
        end
        n_cmp++; if (glitch_cnt != 0 || ready_err != 0) begin n_bad++; $display("FAIL rr_clean: glitches %0d ready_errs %0d want 0", glitch_cnt, ready_err); end
    endtask

    task automatic test_rr_pointer();
        logic [9:0] exp3, exp1;
        apply_reset();
        align_no_tick();
        req_data[23:16] = 8'h22;
        req_valid       = 4'b0100;
        clear_logs();
        run(1);
        req_valid = '0;
        wait_done(1, 1'b0, "ptr_first_done");
        align_no_tick();
        req_data[15:8]  = 8'h31;
        req_data[31:24] = 8'h33;
        req_valid       = 4'b1010;
        clear_logs();
        run(1);
        req_valid       = 4'b0010;
        req_data[31:24] = 8'h00;
        wait_grants(2, "ptr_grants");
        req_valid = '0;
        wait_done(2, 1'b0, "ptr_done");
        exp3 = {1'b1, 8'h33, 1'b0};
        exp1 = {1'b1, 8'h31, 1'b0};
        n_cmp++; if (grant_q.size() < 2 || grant_q[0] != 3 || grant_q[1] != 1) begin n_bad++; $display("FAIL ptr_order: got %0d grants, want req3 then req1", grant_q.size()); end
        n_cmp++; if (frame_bits(0) !== exp3) begin n_bad++; $display("FAIL ptr_latched_frame: got %b want %b", frame_bits(0), exp3); end
        n_cmp++; if (frame_bits(10) !== exp1) begin n_bad++; $display("FAIL ptr_second_frame: got %b want %b", frame_bits(10), exp1); end
        n_cmp++; if (active_id !== 2'd1) begin n_bad++; $display("FAIL ptr_active_id: got %0d want 1", active_id); end
    endtask

    task automatic test_two_stop_bits();
        int ones = 0;
        apply_reset();
        align_no_tick();
        req_data2[7:0] = 8'hFF;
        req_valid2     = 2'b01;
        clear_logs();
        run(1);
        req_valid2 = '0;
        wait_done(1, 1'b1, "stop2_done");
        for (int k = 1; k <= 10; k++) if (k < bits2_q.size() && bits2_q[k] === 1'b1) ones++;
        n_cmp++; if (bits2_q.size() < 1 || bits2_q[0] !== 1'b0) begin n_bad++; $display("FAIL stop2_start: start period not low"); end
        n_cmp++; if (ones != 10) begin n_bad++; $display("FAIL stop2_high: got %0d high periods want 10", ones); end
        n_cmp++; if (done2_q.size() != 1 || bits_cyc.size() < 12 || done2_q[0] != bits_cyc[11]) begin n_bad++; $display("FAIL stop2_done_time: count %0d, want 1 at end of second stop period", done2_q.size()); end
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        align_no_tick();
        req_data[15:8] = 8'hA5;
        req_valid      = 4'b0010;
        clear_logs();
        run(1);
        req_valid = '0;
        wait_bits(6, "midreset_bits");
        run(3);
        n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL midreset_bit4: got %b want 0", tx); end
        reset = 1'b1;
        #1;
        n_cmp++; if (tx !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL midreset_async: tx %b busy %b want 1 0", tx, busy); end
        run(2);
        reset = 1'b0;
        run(2 * DIV);
        n_cmp++; if (done_q.size() != 0) begin n_bad++; $display("FAIL midreset_no_done: got %0d pulses want 0", done_q.size()); end
        align_no_tick();
        req_data[7:0]   = 8'h01;
        req_data[31:24] = 8'h03;
        req_valid       = 4'b1001;
        clear_logs();
        run(1);
        req_valid = '0;
        n_cmp++; if (grant_q.size() != 1 || grant_q[0] != 0) begin n_bad++; $display("FAIL midreset_ptr: got %0d grants (first %0d) want one of req0", grant_q.size(), (grant_q.size() > 0) ? grant_q[0] : -1); end
        wait_done(1, 1'b0, "midreset_done");
    endtask

    task automatic test_tick_alignment();
        int ones = 0;
        apply_reset();
        run_until_tick();
        req_data[7:0] = 8'h3C;
        req_valid     = 4'b0001;
        clear_logs();
        run(1);
        req_valid = '0;
        wait_bits(2, "align_bits");
        n_cmp++; if (bits_q.size() < 2 || bits_q[0] !== 1'b1 || bits_q[1] !== 1'b0) begin n_bad++; $display("FAIL align_start: start bit not deferred to the following tick"); end
        n_cmp++; if (bits_cyc.size() < 2 || bits_cyc[1] - bits_cyc[0] != DIV) begin n_bad++; $display("FAIL align_gap: start not one tick after arbitration"); end
        wait_done(1, 1'b0, "align_done");
        run(2);
        clear_logs();
        run(3 * DIV);
        foreach (bits_q[k]) if (bits_q[k] === 1'b1) ones++;
        n_cmp++; if (grant_q.size() != 0) begin n_bad++; $display("FAIL idle_ready: got %0d pulses want 0", grant_q.size()); end
        n_cmp++; if (bits_q.size() != 3 || ones != 3) begin n_bad++; $display("FAIL idle_tx: got %0d high of %0d samples want 3 of 3", ones, bits_q.size()); end
        n_cmp++; if (busy !== 1'b0 || tx !== 1'b1) begin n_bad++; $display("FAIL idle_state: busy %b tx %b want 0 1", busy, tx); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_rr_pointer();
        test_two_stop_bits();
        test_reset_mid_frame();
        test_tick_alignment();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
